// File: rtl/atm_input_ctrl_pkg.sv
// Shared definitions for the ATM input conditioner: card/menu codes,
// amount steps, raw-input indices and small encode/arithmetic helpers.
package atm_input_ctrl_pkg;

  // Card codes consumed by the ATM FSM
  localparam logic [1:0] CARD_NONE    = 2'b00;
  localparam logic [1:0] CARD_INVALID = 2'b01;
  localparam logic [1:0] CARD_VALID   = 2'b10;

  // Menu codes consumed by the ATM FSM
  localparam logic [2:0] MENU_NONE     = 3'b000;
  localparam logic [2:0] MENU_BALANCE  = 3'b001;
  localparam logic [2:0] MENU_RAPID    = 3'b010;
  localparam logic [2:0] MENU_WITHDRAW = 3'b011;
  localparam logic [2:0] MENU_DEPOSIT  = 3'b100;
  localparam logic [2:0] MENU_EXIT     = 3'b101;

  // Amount entry constants
  localparam logic [7:0] STEP_SMALL   = 8'd1;
  localparam logic [7:0] STEP_LARGE   = 8'd10;
  localparam logic [7:0] RAPID_AMOUNT = 8'd20;

  // Positions of each raw input in the conditioned vector
  localparam int IDX_CARD_VALID   = 0;
  localparam int IDX_CARD_INVALID = 1;
  localparam int IDX_MENU_LO      = 2;
  localparam int IDX_MENU_HI      = 6;
  localparam int IDX_CONFIRM      = 7;
  localparam int IDX_UP           = 8;
  localparam int IDX_DOWN         = 9;
  localparam int IDX_CLEAR        = 10;
  localparam int IDX_STEP_LARGE   = 11;
  localparam int NUM_RAW          = 12;

  // Count of set bits in the menu selection
  function automatic logic [2:0] menu_popcount(input logic [4:0] sel);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, sel[i]};
    end
    return n;
  endfunction

  // Exactly one bit k set -> code k+1; anything else -> MENU_NONE
  function automatic logic [2:0] menu_encode(input logic [4:0] sel);
    logic [2:0] code;
    code = MENU_NONE;
    case (sel)
      5'b00001: code = MENU_BALANCE;
      5'b00010: code = MENU_RAPID;
      5'b00100: code = MENU_WITHDRAW;
      5'b01000: code = MENU_DEPOSIT;
      5'b10000: code = MENU_EXIT;
      default:  code = MENU_NONE;
    endcase
    return code;
  endfunction

  // Saturating 8-bit add, computed in 9 bits
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Subtract clamped at zero
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

endpackage

// File: rtl/atm_input_ctrl_debounce.sv
// Two-flop synchroniser, counter debouncer and registered rise pulse for
// one raw switch or button. The exported level is delayed one cycle so it
// changes on the same edge the rise pulse appears.
module atm_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: sync chain, mismatch counter, level flip and edge detect
  always_comb begin
    sync1_d     = din;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = '0;
    level_dly_d = level_q;
    rise_d      = level_q & ~level_dly_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously at any time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      rise_q      <= rise_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level = level_dly_q;
  assign rise  = rise_q;

endmodule

// File: rtl/atm_input_ctrl.sv
// ATM input conditioner: debounces every board input, encodes card and
// menu codes, and owns the user-entered transaction amount.
//
// confirm_btn is a one-cycle strobe with no back-pressure: in the cycle it
// is high, deposit_amount/withdraw_amount hold the value being confirmed;
// the amount clears on the following edge.
module atm_input_ctrl
  import atm_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_card_valid,
  input  logic       sw_card_invalid,
  input  logic [4:0] sw_menu,
  input  logic       btn_confirm,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clear,
  input  logic       sw_step_large,
  output logic [1:0] card_input,
  output logic [2:0] menu_input,
  output logic       confirm_btn,
  output logic [7:0] deposit_amount,
  output logic [7:0] withdraw_amount,
  output logic       menu_err
);

  logic [NUM_RAW-1:0] raw;
  logic [NUM_RAW-1:0] lvl;
  logic [NUM_RAW-1:0] rise;
  logic [4:0]         menu_lvl;
  logic [7:0]         step;
  logic [7:0]         amount_q, amount_d;
  logic               unused_rise;

  assign raw = {sw_step_large, btn_clear, btn_down, btn_up, btn_confirm,
                sw_menu, sw_card_invalid, sw_card_valid};

  for (genvar g = 0; g < NUM_RAW; g++) begin : g_deb
    atm_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .din  (raw[g]),
      .level(lvl[g]),
      .rise (rise[g])
    );
  end

  // Switch inputs only use their levels; their pulses are intentionally dropped
  assign unused_rise = ^{rise[IDX_STEP_LARGE], rise[IDX_MENU_HI:IDX_MENU_LO],
                         rise[IDX_CARD_INVALID], rise[IDX_CARD_VALID]};

  assign menu_lvl = lvl[IDX_MENU_HI:IDX_MENU_LO];

  // Decode card, menu and step selection from accepted levels
  always_comb begin
    card_input = CARD_NONE;
    if (lvl[IDX_CARD_VALID] && !lvl[IDX_CARD_INVALID]) begin
      card_input = CARD_VALID;
    end else if (lvl[IDX_CARD_INVALID] && !lvl[IDX_CARD_VALID]) begin
      card_input = CARD_INVALID;
    end
    menu_input = menu_encode(menu_lvl);
    menu_err   = (menu_popcount(menu_lvl) > 3'd1);
    step       = lvl[IDX_STEP_LARGE] ? STEP_LARGE : STEP_SMALL;
  end

  // Amount update: card removal, then confirm, clear, up/down conflict, up, down
  always_comb begin
    amount_d = amount_q;
    if (card_input == CARD_NONE) begin
      amount_d = 8'd0;
    end else if (rise[IDX_CONFIRM]) begin
      amount_d = 8'd0;
    end else if (rise[IDX_CLEAR]) begin
      amount_d = 8'd0;
    end else if (rise[IDX_UP] && rise[IDX_DOWN]) begin
      amount_d = amount_q;
    end else if (rise[IDX_UP]) begin
      amount_d = sat_add(amount_q, step);
    end else if (rise[IDX_DOWN]) begin
      amount_d = sat_sub(amount_q, step);
    end
  end

  // Amount register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      amount_q <= 8'd0;
    end else begin
      amount_q <= amount_d;
    end
  end

  assign confirm_btn     = rise[IDX_CONFIRM];
  assign deposit_amount  = amount_q;
  assign withdraw_amount = (menu_input == MENU_RAPID) ? RAPID_AMOUNT : amount_q;

endmodule
